pong_frame_loader: RTL
======================

# pong_frame_loader

Upstream stage of the 17-pixel NeoPixel controller. Converts the Pong game state into per-pixel colour loads on one request: ball position, paddle activity and an optional ball trail. It writes all NUM_NPX pixel registers through the controller's load port, then issues one go. It obeys the controller's ready handshake and coalesces requests that arrive while a frame is in flight.

## Interface
- NUM_NPX, 17: pixels on the strand; pixel 0 is the left paddle, pixel NUM_NPX-1 the right paddle.
- BALL_RED, 8'hFF: red level of the ball pixel.
- PAD_ON, 8'h40: blue level of an active paddle.
- PAD_DIM, 8'h04: blue level of an idle paddle.
- TRAIL_RED, 8'h20: red level of the trail pixel.
- CLOCK_50  in  1  sole clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- update  in  1  one-cycle frame request.
- ball_pos  in  $clog2(NUM_NPX)  ball pixel; a value ≥ NUM_NPX means no ball.
- pad_l_act, pad_r_act  in  1 each  paddle highlight.
- ready  in  1  from the controller; high means loads and go are accepted.
- red, green, blue  out  8 each  colour for the current load.
- pixel  out  $clog2(NUM_NPX)  pixel index for the current load.
- load, go  out  1 each  controller strobes.
- busy  out  1  high in any state other than IDLE, or while a request is pending.
- frames_sent  out  16  count of go pulses; wraps at 16'hFFFF→0.

## Operation
- States are IDLE, LOAD, GO, WAIT_ACK.
- pending flag:
  - set by update in any state;
  - cleared when a frame starts.
  - Multiple updates during a frame coalesce into one frame.
- IDLE:
  - When pending|update and ready are both high, latch ball_pos, pad_l_act and pad_r_act into the snapshot registers, clear idx, and go to LOAD.
  - Otherwise stay in IDLE.
- LOAD:
  - load = ready, pixel = idx, colour = f(idx, snapshot).
  - When ready is high, idx increments. At idx = NUM_NPX-1 with ready high, go to GO.
  - When ready is low, hold idx, keep load low, and stay in LOAD (pause, no restart).
- GO:
  - When ready is high, assert go for exactly one cycle, increment frames_sent, copy the snapshot ball_pos to prev_pos, and go to WAIT_ACK.
  - When ready is low, wait in GO.
- WAIT_ACK: stay until ready is low, then go to IDLE. This stops a stale high ready from starting the next frame.
- Colour function, first match wins; green is always 0:
  - ball: idx == snap_ball → red = BALL_RED, blue = 0. The ball overrides a paddle.
  - paddle: idx == 0 or NUM_NPX-1 → blue = PAD_ON if that side's activity bit is set, else PAD_DIM.
  - trail: see Configuration.
  - otherwise all colours 0.
- Outputs are combinational from registered state and idx only. They do not depend on update.
- Reset drives:
  - state = IDLE, idx = 0, pending = 0;
  - snapshot registers = 0, prev_pos = NUM_NPX (no trail);
  - frames_sent = 0;
  - all outputs 0 (busy = 0).
- Reset mid-frame drops the frame with no go. The controller is reset independently.

## Timing
- If update is sampled at edge E0 with ready high in IDLE:
  - load is high for E1..E17 with pixel 0..16;
  - go is high on the cycle starting at E18;
  - at least 2 cycles pass before the next frame can start.
- The snapshot is taken at E0. Input changes after E0 do not affect that frame.
- update on the same edge as the GO→WAIT_ACK transition sets pending and is serviced next.
- frames_sent wraps silently.

## Configuration
- FRAME_TRAIL_EN defined:
  - prev_pos is kept.
  - prev_pos gets red = TRAIL_RED when all of the following hold: prev_pos ≠ snap_ball, prev_pos is in 1..NUM_NPX-2, and prev_pos < NUM_NPX.
- FRAME_TRAIL_EN undefined:
  - no prev_pos register and no trail;
  - all other behaviour is identical.

## Structure
- Package pong_npx_pkg holds:
  - state enum loader_state_t;
  - colour constants;
  - localparam PIX_W = $clog2(NUM_NPX).
- One sub-module, npx_color_map: pure combinational mapping of (idx, snapshot, prev_pos) to {red, green, blue}, with the trail logic under FRAME_TRAIL_EN.

## Test plan
- Reset, then ready=1 and update with ball_pos=5 and both paddles idle → loads in order:
  - pixel 0: blue 04;
  - pixel 5: red FF;
  - pixel 16: blue 04;
  - all others 0;
  - then one go at E18; frames_sent=1.
- ball_pos=0 with pad_l_act=1 → pixel 0 gets red FF, blue 0 (ball wins); pixel 16 gets blue 04.
- ready forced low during LOAD at idx 8 for 10 cycles → load low and idx held; resume at pixel 8; exactly 17 loads total.
- Three updates during a frame → exactly one extra frame, using the inputs present at its start; frames_sent=2.
- FRAME_TRAIL_EN defined, frames with ball_pos 5 then 6 → second frame has pixel 5 red 20 and pixel 6 red FF. Undefined: pixel 5 is 0.
- reset_n low at idx 10 → all outputs 0 immediately with no go; next update gives a full 17-load frame.

Source files
------------

// File: rtl/pong_npx_pkg.sv
// Shared definitions for the Pong frame loader feeding the NeoPixel controller.
// Holds the strand geometry, colour levels and the loader state encoding.
// Optional feature macro used by the importing files: FRAME_TRAIL_EN.
package pong_npx_pkg;

   localparam int unsigned NUM_NPX = 17;
   localparam int unsigned PIX_W   = $clog2(NUM_NPX);

   localparam logic [7:0] BALL_RED  = 8'hFF;
   localparam logic [7:0] PAD_ON    = 8'h40;
   localparam logic [7:0] PAD_DIM   = 8'h04;
   localparam logic [7:0] TRAIL_RED = 8'h20;

   // Right paddle index, and the out-of-range value meaning "no previous ball".
   localparam logic [PIX_W-1:0] LAST_PIX = PIX_W'(NUM_NPX - 1);
   localparam logic [PIX_W-1:0] NO_PREV  = PIX_W'(NUM_NPX);

   typedef enum logic [1:0] {
      StIdle,
      StLoad,
      StGo,
      StWaitAck
   } loader_state_t;

endpackage

// File: rtl/npx_color_map.sv
// Pure combinational colour lookup for one pixel of a Pong frame.
// Ports:
//   idx        pixel being loaded
//   snap_ball  snapshot ball position (>= NUM_NPX means no ball)
//   snap_pad_l left paddle activity snapshot
//   snap_pad_r right paddle activity snapshot
//   prev_pos   ball position of the previous frame (only with FRAME_TRAIL_EN)
//   red/green/blue  colour for idx; green is always zero
// Priority: ball, then paddles, then trail (FRAME_TRAIL_EN), else dark.
module npx_color_map
   import pong_npx_pkg::*;
(
   input  logic [PIX_W-1:0] idx,
   input  logic [PIX_W-1:0] snap_ball,
   input  logic             snap_pad_l,
   input  logic             snap_pad_r,
`ifdef FRAME_TRAIL_EN
   input  logic [PIX_W-1:0] prev_pos,
`endif
   output logic [7:0]       red,
   output logic [7:0]       green,
   output logic [7:0]       blue
);

   always_comb begin
      red   = 8'h00;
      green = 8'h00;
      blue  = 8'h00;
      if (idx == snap_ball) begin
         red = BALL_RED;
      end else if (idx == '0) begin
         blue = snap_pad_l ? PAD_ON : PAD_DIM;
      end else if (idx == LAST_PIX) begin
         blue = snap_pad_r ? PAD_ON : PAD_DIM;
`ifdef FRAME_TRAIL_EN
      // Trail never lands on a paddle; idx != snap_ball already excludes the ball.
      end else if (idx == prev_pos && prev_pos != '0 && prev_pos < LAST_PIX) begin
         red = TRAIL_RED;
`endif
      end
   end

endmodule

// File: rtl/pong_frame_loader.sv
// Converts the Pong game state into a full strand of pixel loads plus one go
// strobe for the NeoPixel controller, honouring its ready handshake.
// Ports:
//   CLOCK_50, reset_n   clock and asynchronous active-low reset
//   update              one-cycle frame request (coalesced while busy)
//   ball_pos            ball pixel, >= NUM_NPX means no ball
//   pad_l_act/pad_r_act paddle highlight bits
//   ready               controller accepts load/go while high
//   red/green/blue      colour of the current load
//   pixel               index of the current load
//   load, go            controller strobes
//   busy                frame in flight or request pending
//   frames_sent         number of go pulses, wrapping
// Macro FRAME_TRAIL_EN adds a dim trail at the previous frame's ball position.
module pong_frame_loader
   import pong_npx_pkg::*;
(
   input  logic             CLOCK_50,
   input  logic             reset_n,
   input  logic             update,
   input  logic [PIX_W-1:0] ball_pos,
   input  logic             pad_l_act,
   input  logic             pad_r_act,
   input  logic             ready,
   output logic [7:0]       red,
   output logic [7:0]       green,
   output logic [7:0]       blue,
   output logic [PIX_W-1:0] pixel,
   output logic             load,
   output logic             go,
   output logic             busy,
   output logic [15:0]      frames_sent
);

   loader_state_t    state_q, state_d;
   logic [PIX_W-1:0] idx_q, idx_d;
   logic [PIX_W-1:0] snap_ball_q, snap_ball_d;
   logic             snap_l_q, snap_l_d;
   logic             snap_r_q, snap_r_d;
   logic             pending_q, pending_d;
   logic [15:0]      frames_q, frames_d;
`ifdef FRAME_TRAIL_EN
   logic [PIX_W-1:0] prev_q, prev_d;
`endif

   logic       in_load;
   logic [7:0] map_red, map_green, map_blue;

   npx_color_map u_color_map (
      .idx        (idx_q),
      .snap_ball  (snap_ball_q),
      .snap_pad_l (snap_l_q),
      .snap_pad_r (snap_r_q),
`ifdef FRAME_TRAIL_EN
      .prev_pos   (prev_q),
`endif
      .red        (map_red),
      .green      (map_green),
      .blue       (map_blue)
   );

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      snap_ball_d = snap_ball_q;
      snap_l_d    = snap_l_q;
      snap_r_d    = snap_r_q;
      frames_d    = frames_q;
      // Any number of requests collapse into this one flag.
      pending_d   = pending_q | update;
`ifdef FRAME_TRAIL_EN
      prev_d      = prev_q;
`endif
      load        = 1'b0;
      go          = 1'b0;
      pixel       = '0;
      in_load     = 1'b0;

      unique case (state_q)
         StIdle: begin
            if ((pending_q | update) & ready) begin
               snap_ball_d = ball_pos;
               snap_l_d    = pad_l_act;
               snap_r_d    = pad_r_act;
               idx_d       = '0;
               pending_d   = 1'b0;
               state_d     = StLoad;
            end
         end
         StLoad: begin
            in_load = 1'b1;
            load    = ready;
            pixel   = idx_q;
            // A low ready pauses the sweep in place rather than restarting it.
            if (ready) begin
               if (idx_q == LAST_PIX) begin
                  idx_d   = '0;
                  state_d = StGo;
               end else begin
                  idx_d = idx_q + PIX_W'(1);
               end
            end
         end
         StGo: begin
            go = ready;
            if (ready) begin
               frames_d = frames_q + 16'd1;
`ifdef FRAME_TRAIL_EN
               prev_d   = snap_ball_q;
`endif
               state_d  = StWaitAck;
            end
         end
         StWaitAck: begin
            // Ready must drop first so a stale high ready cannot launch a frame.
            if (!ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= StIdle;
         idx_q       <= '0;
         snap_ball_q <= '0;
         snap_l_q    <= 1'b0;
         snap_r_q    <= 1'b0;
         pending_q   <= 1'b0;
         frames_q    <= 16'd0;
`ifdef FRAME_TRAIL_EN
         prev_q      <= NO_PREV;
`endif
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         snap_ball_q <= snap_ball_d;
         snap_l_q    <= snap_l_d;
         snap_r_q    <= snap_r_d;
         pending_q   <= pending_d;
         frames_q    <= frames_d;
`ifdef FRAME_TRAIL_EN
         prev_q      <= prev_d;
`endif
      end
   end

   assign red         = in_load ? map_red   : 8'h00;
   assign green       = in_load ? map_green : 8'h00;
   assign blue        = in_load ? map_blue  : 8'h00;
   assign busy        = (state_q != StIdle) | pending_q;
   assign frames_sent = frames_q;

endmodule
